aes128_decrypt_core: RTL and testbench

Iterative AES-128 decryption engine: the inverse-cipher counterpart of the encryption core. Accepts a 128-bit key and ciphertext on a one-cycle `start` pulse, expands the key schedule internally, runs the ten inverse rounds one per cycle, and returns plaintext with a one-cycle `done` pulse. Uses the same start/busy/done/fault_flag handshake as the encryption core, so the existing vector bench style (key/text/expected triples, latency histogram) applies unchanged. Ships with its own inverse S-box submodule and instantiates the forward S-box for key expansion.

---
 rtl/aes128_decrypt_core.sv | 205 ++++++++++++++++++++
 tb/tb_aes128_decrypt_core.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/aes128_decrypt_core.sv
// rtl/aes128_decrypt_core.sv - iterative AES-128 inverse cipher, one round per cycle
// Key schedule is expanded into an 11-entry array first, then rounds walk it backwards.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = TBL[a];
endmodule

module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign y = TBL[a];
endmodule

module aes128_decrypt_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] ciphertext,
  output logic         busy,
  output logic         done,
  output logic [127:0] plaintext,
  output logic         fault_flag
);
  typedef enum logic [2:0] {IDLE, KEXP, ARK0, ROUND, FINAL} state_t;

  state_t       fsm_q, fsm_d;
  logic [127:0] st_q, st_d, pt_q, pt_d;
  logic [127:0] rk_q [0:10];
  logic [127:0] rk_d [0:10];
  logic [3:0]   rcnt_q, rcnt_d;
  logic         busy_q, busy_d, done_q, done_d, fault_q, fault_d;

  logic [127:0] isr, isb, prev_rk, new_rk;
  logic [31:0]  rot, sub, tw;
  logic [3:0]   kidx;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (m[0] ? b : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  // Circulant {0e,0b,0d,09}: output row r takes coefficient (k-r) mod 4 for input byte k.
  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [3:0]   coef [0:3];
    logic [7:0]   acc;
    coef[0] = 4'he; coef[1] = 4'hb; coef[2] = 4'hd; coef[3] = 4'h9;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(s[127-32*c-8*k -: 8], coef[(k - r + 4) % 4]);
        o[127-32*c-8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // InvShiftRows: row r rotates right by r columns.
  always_comb begin
    isr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        isr[127-8*(r+4*c) -: 8] = st_q[127-8*(r+4*((c-r+4)%4)) -: 8];
  end

  for (genvar i = 0; i < 16; i++) begin : g_isb
    aes_inv_sbox u_isb (.a(isr[127-8*i -: 8]), .y(isb[127-8*i -: 8]));
  end

  assign kidx    = (rcnt_q == 4'd0) ? 4'd0 : rcnt_q - 4'd1;
  assign prev_rk = rk_q[kidx];
  assign rot     = {prev_rk[23:0], prev_rk[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_sb
    aes_sbox u_sb (.a(rot[31-8*j -: 8]), .y(sub[31-8*j -: 8]));
  end

  assign tw = sub ^ {rcon(rcnt_q), 24'h000000};
  always_comb begin
    new_rk[127:96] = prev_rk[127:96] ^ tw;
    new_rk[95:64]  = prev_rk[95:64]  ^ new_rk[127:96];
    new_rk[63:32]  = prev_rk[63:32]  ^ new_rk[95:64];
    new_rk[31:0]   = prev_rk[31:0]   ^ new_rk[63:32];
  end

  always_comb begin
    fsm_d   = fsm_q;
    st_d    = st_q;
    pt_d    = pt_q;
    rk_d    = rk_q;
    rcnt_d  = rcnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fault_d = fault_q | (start & busy_q);
    case (fsm_q)
      IDLE: if (start) begin
        st_d    = ciphertext;
        rk_d[0] = key;
        fault_d = 1'b0;
        rcnt_d  = 4'd1;
        busy_d  = 1'b1;
        fsm_d   = KEXP;
      end
      KEXP: begin
        rk_d[rcnt_q] = new_rk;
        if (rcnt_q == 4'd10) fsm_d = ARK0;
        else                 rcnt_d = rcnt_q + 4'd1;
      end
      ARK0: begin
        st_d   = st_q ^ rk_q[10];
        rcnt_d = 4'd9;
        fsm_d  = ROUND;
      end
      ROUND: begin
        st_d   = inv_mix(isb ^ rk_q[rcnt_q]);
        rcnt_d = rcnt_q - 4'd1;
        if (rcnt_q == 4'd1) fsm_d = FINAL;
      end
      FINAL: begin
        pt_d   = isb ^ rk_q[0];
        done_d = 1'b1;
        busy_d = 1'b0;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      st_q    <= '0;
      pt_q    <= '0;
      rcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      fsm_q   <= fsm_d;
      st_q    <= st_d;
      pt_q    <= pt_d;
      rcnt_q  <= rcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      for (int i = 0; i < 11; i++) rk_q[i] <= rk_d[i];
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign plaintext  = pt_q;
  assign fault_flag = fault_q;
endmodule

// File: tb/tb_aes128_decrypt_core.sv
// tb/tb_aes128_decrypt_core.sv - directed-vector bench for aes128_decrypt_core
module tb_aes128_decrypt_core;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] ciphertext = '0;
  logic         busy, done, fault_flag;
  logic [127:0] plaintext;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes128_decrypt_core dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .ciphertext(ciphertext),
    .busy(busy), .done(done), .plaintext(plaintext), .fault_flag(fault_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [127:0] k, input logic [127:0] c);
    @(negedge clk);
    key = k;
    ciphertext = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
  endtask

  initial begin
    int  lat;
    bit  bad_busy, bad_done, bad_fault, bad_pt, saw_done;

    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pt", plaintext, 0);
    check("reset_fault", fault_flag, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // FIPS-197 C.1
    accept(C1_KEY, C1_CT);
    check("c1_busy", busy, 1);
    wait_done(lat);
    check("c1_lat", lat, 21);
    check("c1_pt", plaintext, C1_PT);
    check("c1_busy_low", busy, 0);
    check("c1_fault", fault_flag, 0);

    // FIPS-197 B, then back-to-back C.1 issued on the done cycle
    accept(B_KEY, B_CT);
    wait_done(lat);
    check("b_lat", lat, 21);
    check("b_pt", plaintext, B_PT);
    accept(C1_KEY, C1_CT);
    check("b2b_busy", busy, 1);
    wait_done(lat);
    check("b2b_gap", lat + 1, 22);
    check("b2b_pt", plaintext, C1_PT);
    check("b2b_fault", fault_flag, 0);

    // All-zero key
    accept(128'h0, Z_CT);
    wait_done(lat);
    check("zero_lat", lat, 21);
    check("zero_pt", plaintext, 128'h0);

    // Start while busy at E+5
    accept(C1_KEY, C1_CT);
    repeat (4) @(posedge clk);
    @(negedge clk);
    key = B_KEY;
    ciphertext = B_CT;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("viol_fault", fault_flag, 1);
    check("viol_busy", busy, 1);
    wait_done(lat);
    check("viol_lat", lat, 21);
    check("viol_pt", plaintext, C1_PT);
    check("viol_fault_held", fault_flag, 1);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("pt_held", plaintext, C1_PT);
    accept(B_KEY, B_CT);
    check("fault_cleared", fault_flag, 0);
    wait_done(lat);
    check("after_viol_pt", plaintext, B_PT);

    // Reset mid-operation at E+15
    accept(C1_KEY, C1_CT);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pt", plaintext, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1;
    end
    check("abort_no_done", saw_done, 0);
    accept(C1_KEY, C1_CT);
    wait_done(lat);
    check("post_rst_lat", lat, 21);
    check("post_rst_pt", plaintext, C1_PT);

    // Idle: inputs wiggle with start low
    bad_busy = 0; bad_done = 0; bad_fault = 0; bad_pt = 0;
    repeat (100) begin
      @(negedge clk);
      key = {$urandom, $urandom, $urandom, $urandom};
      ciphertext = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      if (busy) bad_busy = 1;
      if (done) bad_done = 1;
      if (fault_flag) bad_fault = 1;
      if (plaintext !== C1_PT) bad_pt = 1;
    end
    check("idle_busy", bad_busy, 0);
    check("idle_done", bad_done, 0);
    check("idle_fault", bad_fault, 0);
    check("idle_pt", bad_pt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
